decode_mc_iter: RTL and testbench

//  Multicycle ARM-subset controller: main FSM plus ALU/flag decode in one block. Sits

---
 rtl/decode_pkg.sv | 71 +++++++
 rtl/exe_wait_timer.sv | 44 ++++
 rtl/decode_mc_iter.sv | 203 ++++++++++++++++++++
 tb/tb_decode_mc_iter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the multicycle ARM-subset controller.
// Holds the FSM state encoding, ALU control codes, data-processing cmd
// encodings and small decode helpers used by decode_mc_iter.
// Optional feature macro consumed elsewhere: DECODE_LONGMUL_EN.
package decode_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXER    = 4'd6,
        S_EXEI    = 4'd7,
        S_EXEWAIT = 4'd8,
        S_ALUWB   = 4'd9,
        S_ALUWBHI = 4'd10,
        S_BRANCH  = 4'd11,
        S_UNK     = 4'd12
    } state_e;

    // ALU control codes (3-bit, zero-extended to the port width)
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_ORR  = 3'b011;
    localparam logic [2:0] ALU_DIV  = 3'b100;
    localparam logic [2:0] ALU_UMUL = 3'b101;
    localparam logic [2:0] ALU_SMUL = 3'b110;
    localparam logic [2:0] ALU_MUL  = 3'b111;

    // Data-processing cmd field encodings (Funct[4:1])
    localparam logic [3:0] CMD_ADD  = 4'b0100;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0000;
    localparam logic [3:0] CMD_ORR  = 4'b1100;
    localparam logic [3:0] CMD_MUL  = 4'b1001;
    localparam logic [3:0] CMD_SMUL = 4'b1101;
    localparam logic [3:0] CMD_UMUL = 4'b1111;
    localparam logic [3:0] CMD_DIV  = 4'b0001;

    // Map a cmd onto its ALU code; unrecognised cmds execute as ADD
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        logic [2:0] code;
        case (cmd)
            CMD_ADD:  code = ALU_ADD;
            CMD_SUB:  code = ALU_SUB;
            CMD_AND:  code = ALU_AND;
            CMD_ORR:  code = ALU_ORR;
            CMD_MUL:  code = ALU_MUL;
            CMD_SMUL: code = ALU_SMUL;
            CMD_UMUL: code = ALU_UMUL;
            CMD_DIV:  code = ALU_DIV;
            default:  code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Cmds handled by the variable-latency iterative unit
    function automatic logic is_iter(input logic [3:0] cmd);
        return (cmd == CMD_MUL) || (cmd == CMD_SMUL) ||
               (cmd == CMD_UMUL) || (cmd == CMD_DIV);
    endfunction

    // Cmds producing a 64-bit result with a high word
    function automatic logic is_long(input logic [3:0] cmd);
        return (cmd == CMD_SMUL) || (cmd == CMD_UMUL);
    endfunction

endpackage

// File: rtl/exe_wait_timer.sv
// Wait-cycle counter for the iterative EXECUTE phase.
// Ports:
//   clk, reset  clock / asynchronous active-high reset
//   active      controller is in EXEWAIT this cycle
//   done        iterative unit reports result valid
//   expire_c    combinational: this EXEWAIT cycle is the last one allowed
//   timeout     sticky: an iterative op was forced complete by the limit
module exe_wait_timer #(
    parameter int unsigned EXE_TIMEOUT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic done,
    output logic expire_c,
    output logic timeout
);

    localparam int unsigned CNT_W = (EXE_TIMEOUT > 2) ? $clog2(EXE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXE_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    assign expire_c = active && (cnt == CNT_LAST);

    // Count while waiting; clear on exit so every op starts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            if (active && !done && !expire_c) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            // A result arriving on the final cycle still counts as on time
            if (expire_c && !done) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_mc_iter.sv
// Multicycle ARM-subset controller: main Moore FSM plus ALU/flag decode,
// with a variable-latency EXECUTE for iterative MUL/SMUL/UMUL/DIV.
// Ports:
//   clk, reset           clock / asynchronous active-high reset
//   Op, Funct, Rd        instruction fields instr[27:26], [25:20], [15:12]
//   MulDone              iterative unit result valid (used only in EXEWAIT)
//   FlagW                flag write enables {NZ,CV}
//   PCS NextPC RegW MemW IRWrite AdrSrc ALUSrcA   single-bit enables/selects
//   ResultSrc ALUSrcB ImmSrc RegSrc               2-bit selects
//   ALUControl           ALU operation code
//   MulStart             one-cycle launch pulse for the iterative unit
//   RegWHi               write the high result word
//   ExeTimeout           sticky iterative-op timeout flag
// Build option: DECODE_LONGMUL_EN adds the ALUWBHI high-word writeback for
// SMUL/UMUL; without it RegWHi is tied low.
module decode_mc_iter
    import decode_pkg::*;
#(
    parameter int unsigned ALUCTRL_W   = 3,
    parameter int unsigned EXE_TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 MulDone,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic                 ALUSrcA,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 MulStart,
    output logic                 RegWHi,
    output logic                 ExeTimeout
);

    state_e     state, state_n;
    logic [3:0] cmd;
    logic       iflag, sflag, iter;
    logic       branch;
    logic       expire_c;

    assign cmd   = Funct[4:1];
    assign iflag = Funct[5];
    assign sflag = Funct[0];
    assign iter  = is_iter(cmd);

    exe_wait_timer #(.EXE_TIMEOUT(EXE_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .active   (state == S_EXEWAIT),
        .done     (MulDone),
        .expire_c (expire_c),
        .timeout  (ExeTimeout)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_n    = state;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        RegWHi     = 1'b0;
        MulStart   = 1'b0;
        branch     = 1'b0;
        FlagW      = 2'b00;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = '0;
        ImmSrc     = Op;
        RegSrc     = {Op == 2'b01, Op == 2'b10};
        PCS        = 1'b0;

        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_n   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_n = S_MEMADR;
                    2'b00:   state_n = iflag ? S_EXEI : S_EXER;
                    2'b10:   state_n = S_BRANCH;
                    default: state_n = S_UNK;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_n = sflag ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b01;
                state_n   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                MemW    = 1'b1;
                state_n = S_FETCH;
            end
            S_EXER, S_EXEI: begin
                ALUSrcB    = (state == S_EXEI) ? 2'b01 : 2'b00;
                ALUControl = ALUCTRL_W'(alu_decode(cmd));
                if (iter) begin
                    // Flags wait for the iterative result in ALUWB
                    MulStart = 1'b1;
                    state_n  = S_EXEWAIT;
                end else begin
                    FlagW   = {2{sflag}};
                    state_n = S_ALUWB;
                end
            end
            S_EXEWAIT: begin
                // Keep operand select stable while the iterative unit runs
                ALUSrcB    = {1'b0, iflag};
                ALUControl = ALUCTRL_W'(alu_decode(cmd));
                if (MulDone || expire_c) begin
                    state_n = S_ALUWB;
                end
            end
            S_ALUWB: begin
                RegW       = 1'b1;
                ALUControl = ALUCTRL_W'(alu_decode(cmd));
                if (iter) begin
                    FlagW = {2{sflag}};
                end
`ifdef DECODE_LONGMUL_EN
                state_n = (iter && is_long(cmd)) ? S_ALUWBHI : S_FETCH;
`else
                state_n = S_FETCH;
`endif
            end
            S_ALUWBHI: begin
                RegWHi     = 1'b1;
                ALUControl = ALUCTRL_W'(alu_decode(cmd));
                state_n    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_n   = S_FETCH;
            end
            S_UNK: begin
                state_n = S_FETCH;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase

`ifndef DECODE_LONGMUL_EN
        RegWHi = 1'b0;
`endif

        // Suppress every write/launch while reset is held
        if (reset) begin
            IRWrite  = 1'b0;
            NextPC   = 1'b0;
            RegW     = 1'b0;
            MemW     = 1'b0;
            RegWHi   = 1'b0;
            MulStart = 1'b0;
            FlagW    = 2'b00;
            branch   = 1'b0;
        end

        PCS = ((Rd == 4'hF) && RegW) || branch;
    end

endmodule

// File: tb/tb_decode_mc_iter.sv
// Scoreboard bench for decode_mc_iter: each instruction queues its expected
// per-cycle outputs; the drain loop applies stimulus and compares.
module tb_decode_mc_iter;

    localparam int unsigned ALUCTRL_W = 3;
    localparam int unsigned TO        = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [1:0]           Op = '0;
    logic [5:0]           Funct = '0;
    logic [3:0]           Rd = '0;
    logic                 MulDone = 1'b0;
    logic [1:0]           FlagW;
    logic                 PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]           ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 MulStart, RegWHi, ExeTimeout;

    decode_mc_iter #(.ALUCTRL_W(ALUCTRL_W), .EXE_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .MulDone(MulDone), .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC),
        .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUControl(ALUControl),
        .MulStart(MulStart), .RegWHi(RegWHi), .ExeTimeout(ExeTimeout)
    );

    initial forever #5 clk = ~clk;

    typedef enum logic [3:0] {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR, T_EXER,
        T_EXEI, T_EXEWAIT, T_ALUWB, T_ALUWBHI, T_BRANCH, T_UNK
    } tst_e;

    typedef struct packed {
        logic       irw, npc, regw, memw, pcs, mstart, regwhi;
        logic [1:0] flagw;
        logic [2:0] aluc;
        logic [1:0] ressrc, srcb;
        logic       adr, srca;
        logic [1:0] imm, regsrc;
    } outv_t;

    typedef struct packed {
        tst_e       st;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic       md;
        outv_t      exp;
    } ent_t;

    ent_t  sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    outv_t act_v;

    assign act_v = {IRWrite, NextPC, RegW, MemW, PCS, MulStart, RegWHi, FlagW,
                    ALUControl, ResultSrc, ALUSrcB, AdrSrc, ALUSrcA, ImmSrc, RegSrc};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_alu(input logic [3:0] c);
        case (c)
            4'b0100: return 3'b000;
            4'b0010: return 3'b001;
            4'b0000: return 3'b010;
            4'b1100: return 3'b011;
            4'b0001: return 3'b100;
            4'b1111: return 3'b101;
            4'b1101: return 3'b110;
            4'b1001: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit exp_iter(input logic [3:0] c);
        return (c == 4'b1001) || (c == 4'b1101) || (c == 4'b1111) || (c == 4'b0001);
    endfunction

    function automatic outv_t rst_vec(input logic [1:0] op);
        outv_t v;
        v        = '0;
        v.srca   = 1'b1;
        v.srcb   = 2'b10;
        v.ressrc = 2'b10;
        v.imm    = op;
        v.regsrc = {op == 2'b01, op == 2'b10};
        return v;
    endfunction

    // Expected Moore outputs for a given state and instruction
    function automatic outv_t model(input tst_e s, input logic [1:0] op,
                                    input logic [5:0] f, input logic [3:0] rd);
        outv_t v;
        bit    it;
        it       = exp_iter(f[4:1]);
        v        = '0;
        v.imm    = op;
        v.regsrc = {op == 2'b01, op == 2'b10};
        case (s)
            T_FETCH: begin
                v.irw = 1'b1; v.npc = 1'b1; v.srca = 1'b1;
                v.srcb = 2'b10; v.ressrc = 2'b10;
            end
            T_DECODE: begin
                v.srca = 1'b1; v.srcb = 2'b10; v.ressrc = 2'b10;
            end
            T_MEMADR: v.srcb = 2'b01;
            T_MEMRD:  v.adr = 1'b1;
            T_MEMWB: begin
                v.regw = 1'b1; v.ressrc = 2'b01; v.pcs = (rd == 4'hF);
            end
            T_MEMWR: begin
                v.adr = 1'b1; v.memw = 1'b1;
            end
            T_EXER, T_EXEI: begin
                v.srcb   = (s == T_EXEI) ? 2'b01 : 2'b00;
                v.aluc   = exp_alu(f[4:1]);
                v.mstart = it;
                v.flagw  = (!it && f[0]) ? 2'b11 : 2'b00;
            end
            T_EXEWAIT: begin
                v.srcb = f[5] ? 2'b01 : 2'b00;
                v.aluc = exp_alu(f[4:1]);
            end
            T_ALUWB: begin
                v.regw  = 1'b1;
                v.pcs   = (rd == 4'hF);
                v.aluc  = exp_alu(f[4:1]);
                v.flagw = (it && f[0]) ? 2'b11 : 2'b00;
            end
            T_ALUWBHI: begin
                v.regwhi = 1'b1;
                v.aluc   = exp_alu(f[4:1]);
            end
            T_BRANCH: begin
                v.srcb = 2'b01; v.ressrc = 2'b10; v.pcs = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic push(input tst_e s, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] rd, input logic md);
        ent_t e;
        e.st = s; e.op = op; e.funct = f; e.rd = rd; e.md = md;
        e.exp = model(s, op, f, rd);
        sb.push_back(e);
    endtask

    // Queue one instruction; done_at = EXEWAIT cycle with MulDone (0: never)
    task automatic queue_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                               input int done_at, input logic md_out);
        int n;
        push(T_FETCH, op, f, rd, md_out);
        push(T_DECODE, op, f, rd, md_out);
        case (op)
            2'b01: begin
                push(T_MEMADR, op, f, rd, md_out);
                if (f[0]) begin
                    push(T_MEMRD, op, f, rd, md_out);
                    push(T_MEMWB, op, f, rd, md_out);
                end else begin
                    push(T_MEMWR, op, f, rd, md_out);
                end
            end
            2'b10: push(T_BRANCH, op, f, rd, md_out);
            2'b11: push(T_UNK, op, f, rd, md_out);
            default: begin
                push(f[5] ? T_EXEI : T_EXER, op, f, rd, md_out);
                if (exp_iter(f[4:1])) begin
                    n = (done_at > 0) ? done_at : int'(TO);
                    for (int i = 1; i <= n; i++) begin
                        push(T_EXEWAIT, op, f, rd, (i == done_at));
                    end
                end
                push(T_ALUWB, op, f, rd, md_out);
`ifdef DECODE_LONGMUL_EN
                if (f[4:1] == 4'b1101 || f[4:1] == 4'b1111) begin
                    push(T_ALUWBHI, op, f, rd, md_out);
                end
`endif
            end
        endcase
    endtask

    task automatic drain(input string tag);
        ent_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            Op = e.op; Funct = e.funct; Rd = e.rd; MulDone = e.md;
            #1;
            check_eq({tag, "/", e.st.name()}, 64'(act_v), 64'(e.exp));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_outs", 64'(act_v), 64'(rst_vec(2'b00)));
        check_eq("reset_tmo", 64'(ExeTimeout), 64'(0));
        @(posedge clk); #1 reset = 1'b0;

        queue_instr(2'b00, 6'b001001, 4'h1, 0, 1'b0); drain("ADD_S");
        queue_instr(2'b00, 6'b100100, 4'hF, 0, 1'b0); drain("SUBI_PC");
        queue_instr(2'b00, 6'b011000, 4'h2, 0, 1'b0); drain("ORR");
        queue_instr(2'b00, 6'b000001, 4'h3, 0, 1'b1); drain("AND_S_mdhi");
        queue_instr(2'b00, 6'b010100, 4'h4, 0, 1'b0); drain("CMD_DFLT");
        queue_instr(2'b00, 6'b010011, 4'h5, 5, 1'b0); drain("MUL_S");
        check_eq("MUL_tmo", 64'(ExeTimeout), 64'(0));
        queue_instr(2'b00, 6'b011111, 4'h6, 1, 1'b0); drain("UMUL_S");
        check_eq("UMUL_tmo", 64'(ExeTimeout), 64'(0));
        queue_instr(2'b00, 6'b000010, 4'h7, 0, 1'b0); drain("DIV_TO");
        check_eq("DIV_tmo", 64'(ExeTimeout), 64'(1));
        queue_instr(2'b01, 6'b011001, 4'hF, 0, 1'b0); drain("LDR_PC");
        queue_instr(2'b01, 6'b011000, 4'h8, 0, 1'b0); drain("STR");
        queue_instr(2'b10, 6'b100000, 4'h0, 0, 1'b0); drain("B");
        queue_instr(2'b11, 6'b000000, 4'h0, 0, 1'b0); drain("UNK");

        // Abort an SMUL with reset in its third EXEWAIT cycle
        push(T_FETCH,   2'b00, 6'b011010, 4'h9, 1'b0);
        push(T_DECODE,  2'b00, 6'b011010, 4'h9, 1'b0);
        push(T_EXER,    2'b00, 6'b011010, 4'h9, 1'b0);
        push(T_EXEWAIT, 2'b00, 6'b011010, 4'h9, 1'b0);
        push(T_EXEWAIT, 2'b00, 6'b011010, 4'h9, 1'b0);
        drain("SMUL_pre");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_outs", 64'(act_v), 64'(rst_vec(2'b00)));
        check_eq("midrst_tmo", 64'(ExeTimeout), 64'(0));
        @(posedge clk); #1 reset = 1'b0;

        queue_instr(2'b00, 6'b000011, 4'hA, 0, 1'b0); drain("DIV_post_rst");
        check_eq("post_rst_tmo", 64'(ExeTimeout), 64'(1));
        queue_instr(2'b00, 6'b011010, 4'hB, 3, 1'b0); drain("SMUL");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
